tensor_stream_buffer: RTL and testbench
=======================================

// Module: tensor_stream_buffer
// PURPOSE
//  Parametrised 2-D parameter store for the RNN accelerator, successor to the flat register-array tensor.
//  Adds a valid/ready burst-load port that fills the matrix in row-major order.
//  Adds a valid/ready row-stream port that feeds one row, column by column, to the MAC datapath.
//  Keeps a random-access write/read port for host (Avalon-side) access, and adds a one-cycle global clear.
// PARAMETERS
//  DATA_W    16  element width in bits
//  ROW_BITS  2   log2(rows); ROWS = 1<<ROW_BITS
//  COL_BITS  4   log2(cols); COLS = 1<<COL_BITS
// PORTS
//  clk        in   1                  system clock; all state on posedge
//  rst        in   1                  asynchronous, active-high reset
//  clear      in   1                  zero every element; abort any operation
//  wr_en      in   1                  random-access write strobe
//  wr_r       in   ROW_BITS           random-access write row
//  wr_c       in   COL_BITS           random-access write column
//  wr_data    in   DATA_W             random-access write data
//  rd_r       in   ROW_BITS           random-access read row
//  rd_c       in   COL_BITS           random-access read column
//  rd_data    out  DATA_W             mem[rd_r][rd_c], combinational
//  cmd_load   in   1                  start burst load at (0,0)
//  ld_valid   in   1                  load beat valid
//  ld_data    in   DATA_W             load beat data
//  ld_ready   out  1                  buffer accepts load beat
//  load_done  out  1                  one-cycle pulse after final load beat
//  cmd_stream in   1                  start streaming row cmd_row
//  cmd_row    in   ROW_BITS           row to stream
//  out_valid  out  1                  stream beat valid
//  out_data   out  DATA_W             mem[s_row][col_ptr], combinational
//  out_last   out  1                  high on the final column beat (col_ptr==COLS-1)
//  out_ready  in   1                  downstream accepts beat
//  busy       out  1                  state != IDLE
// BEHAVIOUR
//  Reset state:
//   - all elements 0; state IDLE; pointers 0.
//   - ld_ready=0, load_done=0, out_valid=0, out_last=0, busy=0.
//   - rd_data/out_data reflect zeroed array.
//  FSM IDLE/LOAD/STREAM; commands are sampled only in IDLE and ignored otherwise.
//  IDLE:
//   - cmd_load -> LOAD, ld_ptr<=0.
//   - else cmd_stream -> STREAM, s_row<=cmd_row, col_ptr<=0.
//   - Both commands together: load wins.
//  LOAD:
//   - ld_ready=1.
//   - On ld_valid&ld_ready: mem[ld_ptr] <= ld_data (row-major, ptr = {row,col}); ld_ptr++.
//   - Beat at ld_ptr==ROWS*COLS-1 -> IDLE next cycle and load_done=1 for exactly that cycle.
//   - Total ROWS*COLS beats; no backpressure timeout.
//   - wr_en ignored in LOAD.
//  STREAM:
//   - out_valid=1 from the cycle after cmd_stream (1-cycle command latency).
//   - On out_valid&out_ready: col_ptr++.
//   - Transfer with out_last=1 -> IDLE; out_valid=0 next cycle.
//   - out_data held stable while out_ready=0 unless overwritten.
//   - wr_en allowed in STREAM; a write to the presented element changes out_data the next cycle.
//  wr_en in IDLE/STREAM: mem[wr_r][wr_c] <= wr_data.
//  clear: priority over everything.
//   - All elements <= 0 in one cycle; state -> IDLE.
//   - Pointers 0; no load_done pulse.
//   - Any wr_en or load beat in the same cycle is discarded.
//  rst asserted mid-operation: immediate return to reset state; partial loads are lost.
//  Pointers wrap naturally at their widths; never observed to wrap within a legal operation.
// STRUCTURE
//  tensor_pkg:
//   - typedef enum logic [1:0] {IDLE, LOAD, STREAM} tsb_state_t.
//   - localparam DATA_W_DEFAULT = 16.
//  Sub-module tensor_store:
//   - array with one write port (muxed: clear > load > random write) and two combinational read ports.
//   - Top level holds the FSM, pointers and handshakes.
// TESTING
//  1. rst pulse, then read all 64 addresses -> rd_data=0; busy=0, ld_ready=0, out_valid=0.
//  2. cmd_load, then 64 beats data=i with random ld_valid gaps:
//     - rd(2,5)=37;
//     - load_done high exactly 1 cycle after beat 63; busy=0 after.
//  3. After test 2, cmd_stream row 3 with out_ready toggling 1/0:
//     - beats 48..63 in order, no duplicates or drops;
//     - out_last only on 63; IDLE after.
//  4. cmd_load and cmd_stream in the same cycle -> LOAD entered; stream ignored; wr_en during LOAD leaves array unchanged.
//  5. clear asserted mid-LOAD (after 10 beats):
//     - all rd_data=0; state IDLE; no load_done.
//     - Also: rst mid-STREAM -> out_valid=0 immediately.
//  6. During STREAM with out_ready=0 at col 4: wr_en (row,4)=0xBEEF -> next cycle out_data=0xBEEF.

Source files
------------

// File: rtl/tensor_pkg.sv
// Shared types and defaults for the tensor stream buffer.
// Holds the controller state encoding and the default element width.
package tensor_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2
   } tsb_state_t;

   localparam int DATA_W_DEFAULT = 16;

endpackage

// File: rtl/tensor_store.sv
// Flat register-array element store: one prioritised write port (clear > load > host write)
// and two combinational read ports, addressed row-major as {row, col}.
module tensor_store #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              wr_we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_a_addr,
   output logic [DATA_W-1:0] rd_a_data,
   input  logic [ADDR_W-1:0] rd_b_addr,
   output logic [DATA_W-1:0] rd_b_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] w_words [DEPTH];

   // Each element owns its register so clear can zero the whole array in one cycle.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elem
         logic [DATA_W-1:0] r_word;
         logic              w_ld_hit;
         logic              w_wr_hit;

         assign w_ld_hit = ld_we && (ld_addr == ADDR_W'(gi));
         assign w_wr_hit = wr_we && (wr_addr == ADDR_W'(gi));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_word <= '0;
            end else if (clear) begin
               r_word <= '0;
            end else if (w_ld_hit) begin
               r_word <= ld_data;
            end else if (w_wr_hit) begin
               r_word <= wr_data;
            end
         end

         assign w_words[gi] = r_word;
      end
   endgenerate

   assign rd_a_data = w_words[rd_a_addr];
   assign rd_b_data = w_words[rd_b_addr];

endmodule

// File: rtl/tensor_stream_buffer.sv
// 2-D parameter store with burst-load and row-stream valid/ready ports plus host random access.
// The controller sequences IDLE/LOAD/STREAM; element storage lives in tensor_store.
module tensor_stream_buffer
   import tensor_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEFAULT,
   parameter int ROW_BITS = 2,
   parameter int COL_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                wr_en,
   input  logic [ROW_BITS-1:0] wr_r,
   input  logic [COL_BITS-1:0] wr_c,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [ROW_BITS-1:0] rd_r,
   input  logic [COL_BITS-1:0] rd_c,
   output logic [DATA_W-1:0]   rd_data,
   input  logic                cmd_load,
   input  logic                ld_valid,
   input  logic [DATA_W-1:0]   ld_data,
   output logic                ld_ready,
   output logic                load_done,
   input  logic                cmd_stream,
   input  logic [ROW_BITS-1:0] cmd_row,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_last,
   input  logic                out_ready,
   output logic                busy
);

   localparam int ADDR_W = ROW_BITS + COL_BITS;
   localparam logic [ADDR_W-1:0]   LAST_ADDR = '1;
   localparam logic [COL_BITS-1:0] LAST_COL  = '1;

   tsb_state_t          r_state;
   logic [ADDR_W-1:0]   r_ld_ptr;
   logic [ROW_BITS-1:0] r_s_row;
   logic [COL_BITS-1:0] r_col_ptr;
   logic                r_ld_ready;
   logic                r_load_done;
   logic                r_out_valid;
   logic                r_busy;

   logic w_ld_fire;
   logic w_out_fire;
   logic w_wr_ok;

   assign w_ld_fire  = r_ld_ready && ld_valid;
   assign w_out_fire = r_out_valid && out_ready;
   // Host writes are locked out while a burst load owns the write port.
   assign w_wr_ok    = wr_en && (r_state != LOAD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ld_ptr    <= '0;
         r_s_row     <= '0;
         r_col_ptr   <= '0;
         r_ld_ready  <= 1'b0;
         r_load_done <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (clear) begin
         r_state     <= IDLE;
         r_ld_ptr    <= '0;
         r_s_row     <= '0;
         r_col_ptr   <= '0;
         r_ld_ready  <= 1'b0;
         r_load_done <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_load_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cmd_load) begin
                  r_state    <= LOAD;
                  r_ld_ptr   <= '0;
                  r_ld_ready <= 1'b1;
                  r_busy     <= 1'b1;
               end else if (cmd_stream) begin
                  r_state     <= STREAM;
                  r_s_row     <= cmd_row;
                  r_col_ptr   <= '0;
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            LOAD: begin
               if (w_ld_fire) begin
                  r_ld_ptr <= r_ld_ptr + 1'b1;
                  if (r_ld_ptr == LAST_ADDR) begin
                     r_state     <= IDLE;
                     r_ld_ready  <= 1'b0;
                     r_busy      <= 1'b0;
                     r_load_done <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (w_out_fire) begin
                  r_col_ptr <= r_col_ptr + 1'b1;
                  if (r_col_ptr == LAST_COL) begin
                     r_state     <= IDLE;
                     r_out_valid <= 1'b0;
                     r_busy      <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= IDLE;
               r_ld_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   tensor_store #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_store (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .ld_we     (w_ld_fire),
      .ld_addr   (r_ld_ptr),
      .ld_data   (ld_data),
      .wr_we     (w_wr_ok),
      .wr_addr   ({wr_r, wr_c}),
      .wr_data   (wr_data),
      .rd_a_addr ({rd_r, rd_c}),
      .rd_a_data (rd_data),
      .rd_b_addr ({r_s_row, r_col_ptr}),
      .rd_b_data (out_data)
   );

   assign ld_ready  = r_ld_ready;
   assign load_done = r_load_done;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_valid && (r_col_ptr == LAST_COL);
   assign busy      = r_busy;

endmodule

// File: tb/tb_tensor_stream_buffer.sv
// Randomised self-checking bench for tensor_stream_buffer against a flat-array reference model.
module tb_tensor_stream_buffer;

   localparam int DW   = 16;
   localparam int RB   = 2;
   localparam int CB   = 4;
   localparam int COLS = 1 << CB;
   localparam int N    = (1 << RB) * COLS;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          wr_en;
   logic [RB-1:0] wr_r;
   logic [CB-1:0] wr_c;
   logic [DW-1:0] wr_data;
   logic [RB-1:0] rd_r;
   logic [CB-1:0] rd_c;
   logic [DW-1:0] rd_data;
   logic          cmd_load;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          load_done;
   logic          cmd_stream;
   logic [RB-1:0] cmd_row;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready;
   logic          busy;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] model [N];

   tensor_stream_buffer #(.DATA_W(DW), .ROW_BITS(RB), .COL_BITS(CB)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .wr_en      (wr_en),
      .wr_r       (wr_r),
      .wr_c       (wr_c),
      .wr_data    (wr_data),
      .rd_r       (rd_r),
      .rd_c       (rd_c),
      .rd_data    (rd_data),
      .cmd_load   (cmd_load),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .load_done  (load_done),
      .cmd_stream (cmd_stream),
      .cmd_row    (cmd_row),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_zero();
      for (int i = 0; i < N; i++) model[i] = '0;
   endtask

   task automatic check_array(input string tag);
      for (int i = 0; i < N; i++) begin
         rd_r = RB'(i / COLS);
         rd_c = CB'(i % COLS);
         tick();
         chk_eq(tag, rd_data, model[i]);
      end
   endtask

   task automatic host_write(input int addr, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_r    = RB'(addr / COLS);
      wr_c    = CB'(addr % COLS);
      wr_data = d;
      tick();
      wr_en = 1'b0;
      model[addr] = d;
      $display("[TB] host write addr=%0d data=0x%0h", addr, d);
   endtask

   task automatic start_load();
      cmd_load = 1'b1;
      tick();
      cmd_load = 1'b0;
      chk_eq("load_busy", busy, 1);
      chk_eq("load_ready", ld_ready, 1);
   endtask

   task automatic load_beats(input int n, input bit seq);
      for (int i = 0; i < n; i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            ld_valid = 1'b0;
            tick();
            chk_eq("load_gap_done", load_done, 0);
         end
         ld_valid = 1'b1;
         ld_data  = seq ? DW'(i) : DW'($urandom);
         model[i] = ld_data;
         tick();
         ld_valid = 1'b0;
         if (i == N - 1) begin
            chk_eq("load_done_pulse", load_done, 1);
            chk_eq("load_end_busy", busy, 0);
            chk_eq("load_end_ready", ld_ready, 0);
            $display("[TB] load complete after %0d beats", N);
         end else begin
            chk_eq("load_done_early", load_done, 0);
         end
      end
      if (n == N) begin
         tick();
         chk_eq("load_done_width", load_done, 0);
      end
   endtask

   task automatic stream_row(input int row, input bit toggle);
      int col;
      int cyc;
      cmd_stream = 1'b1;
      cmd_row    = RB'(row);
      tick();
      cmd_stream = 1'b0;
      col = 0;
      cyc = 0;
      while (col < COLS && cyc < 200) begin
         chk_eq("strm_valid", out_valid, 1);
         chk_eq("strm_data", out_data, model[row * COLS + col]);
         chk_eq("strm_last", out_last, (col == COLS - 1) ? 1 : 0);
         out_ready = toggle ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
         tick();
         if (out_ready) begin
            $display("[TB] stream row=%0d col=%0d data=0x%0h", row, col, model[row * COLS + col]);
            col++;
         end
         cyc++;
      end
      out_ready = 1'b0;
      if (col < COLS) chk_eq("strm_timeout", col, COLS);
      chk_eq("strm_end_valid", out_valid, 0);
      chk_eq("strm_end_busy", busy, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_r = '0; wr_c = '0; wr_data = '0;
      rd_r = '0; rd_c = '0; cmd_load = 1'b0; ld_valid = 1'b0; ld_data = '0;
      cmd_stream = 1'b0; cmd_row = '0; out_ready = 1'b0;
      model_zero();

      // Reset state.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_ld_ready", ld_ready, 0);
      chk_eq("rst_out_valid", out_valid, 0);
      chk_eq("rst_load_done", load_done, 0);
      chk_eq("rst_out_last", out_last, 0);
      check_array("rst_array");

      // Sequential burst load with random gaps.
      start_load();
      load_beats(N, 1'b1);
      rd_r = 2'd2; rd_c = 4'd5;
      #1 chk_eq("rd_2_5", rd_data, 37);
      check_array("load_array");

      // Stream the last row with alternating backpressure.
      stream_row(3, 1'b1);

      // Random host writes then readback.
      for (int k = 0; k < 8; k++) host_write($urandom_range(0, N - 1), DW'($urandom));
      check_array("host_array");

      // Simultaneous commands: load wins, host writes during load are dropped.
      cmd_load = 1'b1; cmd_stream = 1'b1; cmd_row = 2'd1;
      tick();
      cmd_load = 1'b0; cmd_stream = 1'b0;
      chk_eq("both_ld_ready", ld_ready, 1);
      chk_eq("both_out_valid", out_valid, 0);
      chk_eq("both_busy", busy, 1);
      wr_en = 1'b1; wr_r = '0; wr_c = '0; wr_data = 16'hABCD;
      tick();
      wr_en = 1'b0;
      check_array("load_wr_ignored");
      load_beats(N, 1'b0);
      check_array("rand_load_array");

      // Clear mid-load, colliding with a load beat and a host write.
      start_load();
      load_beats(10, 1'b0);
      clear = 1'b1; ld_valid = 1'b1; ld_data = DW'($urandom);
      wr_en = 1'b1; wr_r = 2'd1; wr_c = 4'd7; wr_data = 16'h5A5A;
      tick();
      clear = 1'b0; ld_valid = 1'b0; wr_en = 1'b0;
      model_zero();
      chk_eq("clr_busy", busy, 0);
      chk_eq("clr_ld_ready", ld_ready, 0);
      for (int k = 0; k < 3; k++) begin
         chk_eq("clr_load_done", load_done, 0);
         tick();
      end
      check_array("clr_array");

      // Asynchronous reset in the middle of a stream.
      host_write(1 * COLS + 3, 16'h1357);
      cmd_stream = 1'b1; cmd_row = 2'd1;
      tick();
      cmd_stream = 1'b0;
      chk_eq("pre_rst_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk_eq("mid_rst_valid", out_valid, 0);
      chk_eq("mid_rst_busy", busy, 0);
      chk_eq("mid_rst_last", out_last, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_zero();
      rd_r = 2'd1; rd_c = 4'd3;
      #1 chk_eq("mid_rst_array", rd_data, 0);

      // Host write to the element currently presented while stalled.
      for (int c = 0; c < COLS; c++) host_write(2 * COLS + c, DW'($urandom));
      cmd_stream = 1'b1; cmd_row = 2'd2;
      tick();
      cmd_stream = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         chk_eq("hold_pre_data", out_data, model[2 * COLS + c]);
         tick();
      end
      out_ready = 1'b0;
      chk_eq("hold_col4_data", out_data, model[2 * COLS + 4]);
      wr_en = 1'b1; wr_r = 2'd2; wr_c = 4'd4; wr_data = 16'hBEEF;
      tick();
      wr_en = 1'b0;
      model[2 * COLS + 4] = 16'hBEEF;
      chk_eq("hold_beef", out_data, 16'hBEEF);
      chk_eq("hold_valid", out_valid, 1);
      tick();
      chk_eq("hold_stable", out_data, 16'hBEEF);
      out_ready = 1'b1;
      for (int c = 4; c < COLS; c++) begin
         chk_eq("hold_post_data", out_data, model[2 * COLS + c]);
         chk_eq("hold_post_last", out_last, (c == COLS - 1) ? 1 : 0);
         tick();
      end
      out_ready = 1'b0;
      chk_eq("hold_end_valid", out_valid, 0);

      // Random rows with random backpressure.
      for (int k = 0; k < 3; k++) stream_row($urandom_range(0, 3), 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
